// File: rtl/trap_ctrl_pkg.sv
// Shared encodings for the trap sequencer: FSM states, cause codes, mtvec modes, privilege.
// Used by trap_ctrl; the TRAP_CTRL_VECTORED_EN build option lives in trap_ctrl.sv.
package trap_pkg;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_COMMIT   = 2'd1;
    localparam logic [1:0] ST_REDIRECT = 2'd2;

    localparam logic [30:0] EXC_ILLEGAL = 31'd2;
    localparam logic [30:0] EXC_ECALL_M = 31'd11;
    localparam logic [30:0] INT_SOFT_M  = 31'd3;
    localparam logic [30:0] INT_TIMER_M = 31'd7;
    localparam logic [30:0] INT_EXT_M   = 31'd11;

    localparam logic [1:0] DIRECT   = 2'b00;
    localparam logic [1:0] VECTORED = 2'b01;

    localparam logic [1:0] PRIV_M = 2'b11;

    typedef enum logic {
        KIND_TRAP = 1'b0,
        KIND_MRET = 1'b1
    } kind_t;

endpackage

// File: rtl/trap_int_sync.sv
// Flip-flop chain synchronizer with synchronous active-high reset; STAGES >= 1.
module trap_int_sync #(
    parameter int STAGES = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic din,
    output logic dout
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge CLK) begin
        if (RST) begin
            chain <= '0;
        end else begin
            chain[0] <= din;
            for (int i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign dout = chain[STAGES-1];

endmodule

// File: rtl/trap_ctrl.sv
// Trap sequencer: arbitrates exception / interrupt / MRET, pulses the CSR update, then flushes and redirects fetch.
// Build option TRAP_CTRL_VECTORED_EN enables vectored interrupt targets (mtvec mode 2'b01).
import trap_pkg::*;

module trap_ctrl #(
    parameter int INT_SYNC_STAGES = 2,
    parameter int REDIRECT_HOLD   = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        MMU_WAIT,
    input  logic        EXC_EN,
    input  logic [30:0] EXC_CODE,
    input  logic [31:0] EXC_PC,
    input  logic        MRET_EN,
    input  logic [31:0] MRET_PC,
    input  logic        INT_EXT,
    input  logic        INT_TIMER,
    input  logic        INT_SOFT,
    input  logic [31:0] INT_PC,
    input  logic        INT_PC_VALID,
    input  logic        INT_ALLOW,
    input  logic [1:0]  TRAP_VEC_MODE,
    input  logic [31:0] TRAP_VEC_BASE,
    output logic        TRAP_EN,
    output logic [31:0] TRAP_CODE,
    output logic [31:0] TRAP_PC,
    output logic        CHMODE_DO,
    output logic [1:0]  CHMODE_TO,
    output logic        FLUSH,
    output logic        JUMP_EN,
    output logic [31:0] JUMP_PC,
    output logic        BUSY
);

    localparam logic [2:0] HOLD_LAST = 3'(REDIRECT_HOLD - 1);

    logic [1:0]  state;
    logic [2:0]  hold_cnt;
    kind_t       kind_r;
    logic [31:0] cause_r;
    logic [31:0] epc_r;
    logic [31:0] tgt_r;

    logic        int_ext_s;
    logic        int_ok;
    logic        req_any;
    kind_t       req_kind;
    logic [31:0] req_cause;
    logic [31:0] req_pc;
    logic [31:0] req_tgt;
    logic        accept;
    logic        unused_in;

    trap_int_sync #(
        .STAGES(INT_SYNC_STAGES)
    ) u_int_sync (
        .CLK (CLK),
        .RST (RST),
        .din (INT_EXT),
        .dout(int_ext_s)
    );

    // Losing requests are dropped; their sources re-issue or re-arbitrate later.
    always_comb begin
        req_any   = 1'b0;
        req_kind  = KIND_TRAP;
        req_cause = '0;
        req_pc    = '0;
        req_tgt   = TRAP_VEC_BASE;
        int_ok    = INT_ALLOW & INT_PC_VALID & (int_ext_s | INT_SOFT | INT_TIMER);
        if (EXC_EN) begin
            req_any   = 1'b1;
            req_cause = {1'b0, EXC_CODE};
            req_pc    = EXC_PC;
        end else if (int_ok) begin
            req_any = 1'b1;
            req_pc  = INT_PC;
            if (int_ext_s)     req_cause = {1'b1, INT_EXT_M};
            else if (INT_SOFT) req_cause = {1'b1, INT_SOFT_M};
            else               req_cause = {1'b1, INT_TIMER_M};
`ifdef TRAP_CTRL_VECTORED_EN
            if (TRAP_VEC_MODE == VECTORED) begin
                req_tgt = TRAP_VEC_BASE + {req_cause[29:0], 2'b00};
            end
`endif
        end else if (MRET_EN) begin
            req_any  = 1'b1;
            req_kind = KIND_MRET;
            req_tgt  = {MRET_PC[31:2], 2'b00};
        end
    end

`ifdef TRAP_CTRL_VECTORED_EN
    assign unused_in = ^MRET_PC[1:0];
`else
    assign unused_in = ^{TRAP_VEC_MODE, MRET_PC[1:0]};
`endif

    assign accept = (state == ST_IDLE) & ~MMU_WAIT & req_any;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= ST_IDLE;
            hold_cnt <= '0;
            kind_r   <= KIND_TRAP;
            cause_r  <= '0;
            epc_r    <= '0;
            tgt_r    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state  <= ST_COMMIT;
                        kind_r <= req_kind;
                        tgt_r  <= req_tgt;
                        if (req_kind == KIND_TRAP) begin
                            cause_r <= req_cause;
                            epc_r   <= req_pc;
                        end
                    end
                end
                ST_COMMIT: begin
                    state    <= ST_REDIRECT;
                    hold_cnt <= '0;
                end
                ST_REDIRECT: begin
                    if (hold_cnt == HOLD_LAST) state <= ST_IDLE;
                    else                       hold_cnt <= hold_cnt + 3'd1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign TRAP_EN   = (state == ST_COMMIT) && (kind_r == KIND_TRAP);
    assign CHMODE_DO = (state == ST_COMMIT) && (kind_r == KIND_MRET);
    assign CHMODE_TO = CHMODE_DO ? PRIV_M : 2'b00;
    assign TRAP_CODE = cause_r;
    assign TRAP_PC   = epc_r;
    assign FLUSH     = (state == ST_REDIRECT);
    assign JUMP_EN   = (state == ST_REDIRECT);
    assign JUMP_PC   = tgt_r;
    assign BUSY      = (state != ST_IDLE);

endmodule
